ram_bitmask_req_ctrl: RTL and testbench

//  Request/response front end driving port A of ram_dp_bitmask.
//  - After reset, fills every RAM word with INIT_VALUE.
//  - Then accepts valid/ready read and write requests with byte strobes, expanding strobes into the RAM bit mask.
//  - Returns read data through a RSP_DEPTH-entry response FIFO with valid/ready backpressure.

---
 rtl/ram_bitmask_req_ctrl.sv | 99 +++++++++
 tb/tb_ram_bitmask_req_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ram_bitmask_req_ctrl.sv
// ram_bitmask_req_ctrl: init sweep plus valid/ready request front end for port A of ram_dp_bitmask.
// Read data is returned in order through a small response FIFO with backpressure.
module ram_bitmask_req_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int RSP_DEPTH = 4,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                    clock,
   input  logic                    reset,
   output logic                    init_done,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_wr,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    ram_cen,
   output logic                    ram_wen,
   output logic [DATA_WIDTH-1:0]   ram_bwen,
   output logic [ADDR_WIDTH-1:0]   ram_addr,
   output logic [DATA_WIDTH-1:0]   ram_din,
   input  logic [DATA_WIDTH-1:0]   ram_dout
);
   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = $clog2(RSP_DEPTH + 1);

   typedef enum logic [1:0] {START, INIT, RUN} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] cnt;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] fifo [RSP_DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic [CW:0]           occ;
   logic [DATA_WIDTH-1:0] strb_mask;
   logic                  accept, push, pop, init, run;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   for (genvar i = 0; i < DATA_WIDTH / 8; i++) begin : g_mask
      assign strb_mask[8*i +: 8] = {8{req_wstrb[i]}};
   end

   // Occupancy counts the in-flight read so the FIFO can never overflow.
   assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign init      = (state == INIT);
   assign run       = (state == RUN);
   assign req_ready = run && (occ < (CW+1)'(RSP_DEPTH));
   assign accept    = req_valid & req_ready;
   assign push      = inflight;
   assign pop       = rsp_valid & rsp_ready;
   assign rsp_valid = (count != '0);
   assign rsp_rdata = fifo[rd_ptr];

   always_comb begin
      ram_cen  = init | accept;
      ram_wen  = init ? 1'b1 : run & req_wr;
      ram_addr = init ? cnt : run ? req_addr : '0;
      ram_bwen = init ? '1 : (run & req_wr) ? strb_mask : '0;
      ram_din  = init ? INIT_VALUE : (run & req_wr) ? req_wdata : '0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= START;
         cnt       <= '0;
         init_done <= 1'b0;
         inflight  <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         for (int i = 0; i < RSP_DEPTH; i++) fifo[i] <= '0;
      end else begin
         if (state == START) state <= INIT;
         if (init) begin
            cnt <= cnt + ADDR_WIDTH'(1);
            if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
               state     <= RUN;
               init_done <= 1'b1;
            end
         end
         inflight <= accept & ~req_wr;
         if (push) begin
            fifo[wr_ptr] <= ram_dout;
            wr_ptr       <= nxt(wr_ptr);
         end
         if (pop) rd_ptr <= nxt(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_ram_bitmask_req_ctrl.sv
// tb_ram_bitmask_req_ctrl: randomized and directed stimulus with a queue scoreboard,
// a behavioural RAM on the port-A pins and a reference memory model.
module tb_ram_bitmask_req_ctrl;
   localparam int DW = 32;
   localparam int DEPTH = 16;
   localparam int RSP_DEPTH = 3;
   localparam int AW = 4;
   localparam logic [DW-1:0] INIT = 32'h5A5A_0F0F;

   logic          clock = 1'b0;
   logic          reset;
   logic          init_done, req_valid, req_ready, req_wr, rsp_valid, rsp_ready;
   logic [AW-1:0] req_addr, ram_addr;
   logic [DW-1:0] req_wdata, rsp_rdata, ram_bwen, ram_din, ram_dout;
   logic [3:0]    req_wstrb;
   logic          ram_cen, ram_wen;

   ram_bitmask_req_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RSP_DEPTH(RSP_DEPTH), .INIT_VALUE(INIT)) dut (
      .clock(clock), .reset(reset), .init_done(init_done),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_bwen(ram_bwen), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 clock = ~clock;

   // Bit-masked single-port view of the RAM, registered read data.
   logic [DW-1:0] ram [DEPTH];
   always @(posedge clock)
      if (ram_cen) begin
         if (ram_wen) ram[ram_addr] <= (ram[ram_addr] & ~ram_bwen) | (ram_din & ram_bwen);
         else ram_dout <= ram[ram_addr];
      end

   int ecount;
   always @(posedge clock or posedge reset)
      if (reset) ecount <= 0;
      else ecount <= ecount + 1;

   typedef struct { logic [DW-1:0] d; int vis; } exp_t;
   exp_t          q[$];
   logic [DW-1:0] ref_mem [DEPTH];
   int            n_cmp = 0, n_err = 0, n_acc = 0, n_rsp = 0;
   bit            pop_now;

   function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Monitor: reset values, init sweep, response ordering and timing.
   always @(negedge clock) begin
      bit ev;
      pop_now = 1'b0;
      if (reset) begin
         q.delete();
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_rdata", rsp_rdata, 0);
         chk("rst_init_done", init_done, 0);
         chk("rst_req_ready", req_ready, 0);
         chk("rst_ram_cen", ram_cen, 0);
      end else begin
         chk("init_done", init_done, ecount > DEPTH);
         if (ecount == 0) chk("start_cen", ram_cen, 0);
         if (ecount >= 1 && ecount <= DEPTH) begin
            chk("init_cen", ram_cen, 1);
            chk("init_wen", ram_wen, 1);
            chk("init_addr", ram_addr, ecount - 1);
            chk("init_bwen", ram_bwen, '1);
            chk("init_din", ram_din, INIT);
         end
         ev = q.size() > 0 && q[0].vis <= ecount;
         chk("rsp_valid", rsp_valid, ev);
         if (ev && rsp_ready) begin
            chk("rsp_rdata", rsp_rdata, q[0].d);
            void'(q.pop_front());
            pop_now = 1'b1;
            n_rsp++;
         end
      end
   end

   task automatic req(input bit v, input bit wr, input int a, input logic [DW-1:0] d,
                      input logic [3:0] s, input bit rr);
      bit            er;
      logic [DW-1:0] m;
      req_valid = v; req_wr = wr; req_addr = AW'(a); req_wdata = d; req_wstrb = s; rsp_ready = rr;
      @(negedge clock);
      #2;
      er = !reset && ecount > DEPTH && (q.size() + int'(pop_now)) < RSP_DEPTH;
      if (!reset) begin
         chk("req_ready", req_ready, er);
         if (ecount > DEPTH) chk("run_cen", ram_cen, v && er);
      end
      if (v && er) begin
         n_acc++;
         if (wr) begin
            m = '0;
            for (int i = 0; i < 4; i++)
               if (s[i]) begin
                  m[8*i +: 8] = 8'hFF;
                  ref_mem[a][8*i +: 8] = d[8*i +: 8];
               end
            chk("wr_bwen", ram_bwen, m);
            chk("wr_din", ram_din, d);
         end else begin
            chk("rd_bwen", ram_bwen, 0);
            q.push_back('{d: ref_mem[a], vis: ecount + 2});
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n, input bit rr);
      for (int i = 0; i < n; i++) req(0, 0, 0, '0, '0, rr);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT;
   endtask

   initial begin
      int a0, r0;
      req_valid = 0; req_wr = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0; rsp_ready = 1;
      do_reset();
      idle(DEPTH + 3, 1);
      for (int a = 0; a < DEPTH; a++) req(1, 0, a, '0, '0, 1);
      idle(4, 1);
      req(1, 1, 5, 32'hAABBCCDD, 4'b1111, 1);
      req(1, 1, 5, 32'h11223344, 4'b0101, 1);
      req(1, 0, 5, '0, '0, 1);
      chk("strobe_merge_model", ref_mem[5], 32'hAA22CC44);
      idle(4, 1);
      req(1, 1, 3, 32'hDEADBEEF, 4'b1111, 1);
      req(1, 0, 3, '0, '0, 1);
      req(1, 1, 9, 32'h01020304, 4'b0000, 1);
      req(1, 0, 9, '0, '0, 1);
      idle(4, 1);
      a0 = n_acc;
      for (int a = 0; a < 6; a++) req(1, 0, a, '0, '0, 0);
      chk("backpressure_accepts", n_acc - a0, RSP_DEPTH);
      idle(6, 1);
      a0 = n_acc; r0 = n_rsp;
      for (int i = 0; i < 20; i++) req(1, 0, i % DEPTH, '0, '0, 1);
      chk("stream_accepts", n_acc - a0, 20);
      idle(3, 1);
      chk("stream_responses", n_rsp - r0, 20);
      for (int i = 0; i < 400; i++)
         req($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
             $urandom, 4'($urandom), $urandom_range(0, 3) != 0);
      idle(8, 1);
      for (int a = 0; a < 3; a++) req(1, 0, a + 4, '0, '0, 0);
      do_reset();
      idle(DEPTH + 4, 1);
      for (int a = 0; a < 6; a++) req(1, 0, a, '0, '0, 1);
      for (int i = 0; i < 40 && q.size() > 0; i++) idle(1, 1);
      chk("drain_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
